// File: rtl/uart_rx_os_pkg.sv
// uart_rx_os_pkg
//   Shared definitions for the oversampling UART receiver. These are common
//   with the transmitter and the baud-rate generator:
//   - default frame parameters (DBIT, OS, SB_TICK)
//   - 2-bit FSM state encodings
//   - constant helper functions used to size the counters
package uart_rx_os_pkg;

   localparam int DBIT_DEF    = 8;
   localparam int OS_DEF      = 16;
   localparam int SB_TICK_DEF = 16;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   // ceil(log2(v)), never less than 1 so the result is always a usable width
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) begin
            r = i + 1;
         end
      end
      return (r < 1) ? 1 : r;
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// uart_rx_os_if
//   Signal bundle between the receiver and its neighbours.
//   s_tick        oversample tick from the baud generator (1-cycle pulse)
//   rx            raw asynchronous serial line, idle high
//   dout          last received byte, held until the next completion
//   rx_done_tick  1-cycle pulse, dout valid in the same cycle
//   frame_err     1-cycle pulse alongside rx_done_tick when the stop bit was low
//   master: drives the line and the tick, consumes the byte (pad/host side)
//   slave : the receiver itself
interface uart_rx_os_if #(
   parameter int DBIT = 8
) ();

   logic            s_tick;
   logic            rx;
   logic [DBIT-1:0] dout;
   logic            rx_done_tick;
   logic            frame_err;

   modport master (
      output s_tick,
      output rx,
      input  dout,
      input  rx_done_tick,
      input  frame_err
   );

   modport slave (
      input  s_tick,
      input  rx,
      output dout,
      output rx_done_tick,
      output frame_err
   );

endinterface

// File: rtl/uart_rx_os_sync_2ff.sv
// sync_2ff
//   Two-flop synchroniser for a single asynchronous input.
//   clk  in   system clock
//   rst  in   synchronous active-high reset; both flops load RST_VAL
//   d    in   asynchronous input
//   q    out  synchronised output, two clk cycles of latency
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os
//   UART receiver (8N1 by default) driven by a 16x oversampling tick.
//   The rx line is synchronised, the start bit is qualified at its centre and
//   every following bit is sampled at its centre. Each completed frame yields
//   a one-cycle rx_done_tick with the byte on dout; frame_err pulses with it
//   when the stop bit is sampled low. The byte is delivered either way.
//   clk   in      system clock
//   rst   in      synchronous active-high reset
//   bus   slave   s_tick, rx in; dout, rx_done_tick, frame_err out
//
//   state  | meaning
//   IDLE   | line idle, waiting for rx_s low (checked every clk)
//   START  | counting to the centre of the start bit, then re-checking it
//   DATA   | sampling DBIT data bits, LSB first, one per OS ticks
//   STOP   | waiting SB_TICK ticks, then sampling the stop bit and delivering
module uart_rx_os
   import uart_rx_os_pkg::*;
#(
   parameter int DBIT    = DBIT_DEF,
   parameter int SB_TICK = SB_TICK_DEF,
   parameter int OS      = OS_DEF
) (
   input  logic          clk,
   input  logic          rst,
   uart_rx_os_if.slave   bus
);

   localparam int TW = clog2(max2(OS, SB_TICK));
   localparam int BW = clog2(DBIT);

   localparam logic [TW-1:0] TICK_MID  = TW'(OS / 2 - 1);
   localparam logic [TW-1:0] TICK_BIT  = TW'(OS - 1);
   localparam logic [TW-1:0] TICK_STOP = TW'(SB_TICK - 1);
   localparam logic [TW-1:0] TICK_ONE  = TW'(1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DBIT - 1);
   localparam logic [BW-1:0] BIT_ONE   = BW'(1);

   logic            rx_s;
   logic [1:0]      state;
   logic [TW-1:0]   tick_cnt;
   logic [BW-1:0]   bit_cnt;
   logic [DBIT-1:0] shreg;
   logic [DBIT-1:0] dout_q;
   logic            done_q;
   logic            ferr_q;

   sync_2ff #(
      .RST_VAL (1'b1)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (bus.rx),
      .q   (rx_s)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         tick_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         dout_q   <= '0;
         done_q   <= 1'b0;
         ferr_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         ferr_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               // start detect is not tick-qualified, so back-to-back frames
               // lose no time between the stop bit and the next start bit
               if (!rx_s) begin
                  state    <= ST_START;
                  tick_cnt <= '0;
               end
            end
            ST_START: begin
               if (bus.s_tick) begin
                  if (tick_cnt == TICK_MID) begin
                     if (!rx_s) begin
                        state    <= ST_DATA;
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                     end else begin
                        // line went back high before mid-start: glitch
                        state <= ST_IDLE;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + TICK_ONE;
                  end
               end
            end
            ST_DATA: begin
               if (bus.s_tick) begin
                  if (tick_cnt == TICK_BIT) begin
                     tick_cnt <= '0;
                     shreg    <= {rx_s, shreg[DBIT-1:1]};
                     if (bit_cnt == BIT_LAST) begin
                        state <= ST_STOP;
                     end else begin
                        bit_cnt <= bit_cnt + BIT_ONE;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + TICK_ONE;
                  end
               end
            end
            ST_STOP: begin
               if (bus.s_tick) begin
                  if (tick_cnt == TICK_STOP) begin
                     state  <= ST_IDLE;
                     dout_q <= shreg;
                     done_q <= 1'b1;
                     ferr_q <= ~rx_s;
                  end else begin
                     tick_cnt <= tick_cnt + TICK_ONE;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.dout         = dout_q;
   assign bus.rx_done_tick = done_q;
   assign bus.frame_err    = ferr_q;

endmodule
